// File: rtl/radar_emu_pkg.sv
// Shared types and defaults for the radar target emulator.
// Feature macro: TARGET_MOTION_EN (target closes on each echo).
package radar_emu_pkg;

  typedef enum logic [1:0] {
    EMU_IDLE = 2'b00,
    EMU_WAIT = 2'b01,
    EMU_ECHO = 2'b10
  } emu_state_t;

  localparam int METERS_PER_TICK_DEF = 150;
  localparam int RANGE_W = 14;
  localparam int ACC_W   = 15;

endpackage

// File: rtl/rising_edge_detect.sv
// One-register rising edge detector; pulse is combinational
// from the live input and the previous sample.
module rising_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b0;
    else      prev <= in;
  end

  assign pulse = in & ~prev;

endmodule

// File: rtl/radar_target_emulator.sv
// Single radar target: answers trigger pings with a delayed echo.
// Feature macro: TARGET_MOTION_EN (range closes per echo).
module radar_target_emulator
  import radar_emu_pkg::*;
#(
  parameter int METERS_PER_TICK = METERS_PER_TICK_DEF,
  parameter int ECHO_WIDTH      = 3,
  parameter int MAX_RANGE       = 15000,
  parameter int CLOSING_STEP    = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_target,
  input  logic [13:0] target_distance,
  input  logic        target_present,
  input  logic        trigger_radar_transmitter,
  output logic        radar_echo,
  output logic        busy,
  output logic        missed_trigger,
  output logic [7:0]  echo_count,
  output logic [13:0] current_range
);

  localparam logic [ACC_W-1:0] STEP  = ACC_W'(METERS_PER_TICK);
  localparam logic [ACC_W-1:0] MAX_R = ACC_W'(MAX_RANGE);
  localparam logic [3:0]       WLAST = 4'(ECHO_WIDTH - 1);

  emu_state_t         state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [3:0]         wcnt, wcnt_nxt;
  logic [RANGE_W-1:0] range_nxt;
  logic [ACC_W-1:0]   range_ext;
  logic               ping, echo_done;

  rising_edge_detect u_ping (
    .clk   (clk),
    .rst   (rst),
    .in    (trigger_radar_transmitter),
    .pulse (ping)
  );

  assign range_ext = {1'b0, current_range};

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    wcnt_nxt  = wcnt;
    echo_done = 1'b0;
    case (state)
      EMU_IDLE:
        if (ping && target_present && range_ext <= MAX_R) begin
          state_nxt = EMU_WAIT;
          acc_nxt   = '0;
        end
      EMU_WAIT:
        if (acc >= range_ext) begin
          state_nxt = EMU_ECHO;
          wcnt_nxt  = '0;
        end else begin
          acc_nxt = acc + STEP;
        end
      EMU_ECHO:
        if (wcnt == WLAST) begin
          state_nxt = EMU_IDLE;
          echo_done = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 4'd1;
        end
      default: state_nxt = EMU_IDLE;
    endcase
  end

`ifdef TARGET_MOTION_EN
  localparam logic [RANGE_W-1:0] CLOSE = RANGE_W'(CLOSING_STEP);

  // A load on the same edge as a motion step takes priority.
  always_comb begin
    range_nxt = current_range;
    if (load_target)
      range_nxt = target_distance;
    else if (echo_done)
      range_nxt = (current_range >= CLOSE) ? current_range - CLOSE : '0;
  end
`else
  always_comb begin
    range_nxt = current_range;
    if (load_target) range_nxt = target_distance;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= EMU_IDLE;
      acc            <= '0;
      wcnt           <= '0;
      radar_echo     <= 1'b0;
      busy           <= 1'b0;
      missed_trigger <= 1'b0;
      echo_count     <= '0;
      current_range  <= '0;
    end else begin
      state          <= state_nxt;
      acc            <= acc_nxt;
      wcnt           <= wcnt_nxt;
      radar_echo     <= (state_nxt == EMU_ECHO);
      busy           <= (state_nxt != EMU_IDLE);
      missed_trigger <= ping && (state != EMU_IDLE);
      echo_count     <= echo_count + {7'd0, echo_done};
      current_range  <= range_nxt;
    end
  end

endmodule

// File: tb/tb_radar_target_emulator.sv
// Directed bench for radar_target_emulator.
// Honours TARGET_MOTION_EN for the closing-range vectors.
module tb_radar_target_emulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_target;
  logic [13:0] target_distance;
  logic        target_present;
  logic        trig;
  logic        radar_echo;
  logic        busy;
  logic        missed_trigger;
  logic [7:0]  echo_count;
  logic [13:0] current_range;

  int n_vec = 0;
  int n_err = 0;

  radar_target_emulator dut (
    .clk                       (clk),
    .rst                       (rst),
    .load_target               (load_target),
    .target_distance           (target_distance),
    .target_present            (target_present),
    .trigger_radar_transmitter (trig),
    .radar_echo                (radar_echo),
    .busy                      (busy),
    .missed_trigger            (missed_trigger),
    .echo_count                (echo_count),
    .current_range             (current_range)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [13:0] d);
    target_distance = d;
    load_target     = 1'b1;
    tick();
    load_target     = 1'b0;
  endtask

  // Ping on the next edge (k=0), then watch `limit` edges.
  task automatic ping_measure(input int limit,
                              output int lat,
                              output int width,
                              output int rises,
                              output int busy_seen);
    logic prev_e;
    lat = -1; width = 0; rises = 0; busy_seen = 0;
    prev_e = 1'b0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (radar_echo && lat < 0) lat = k;
      if (radar_echo) width++;
      if (radar_echo && !prev_e) rises++;
      if (busy) busy_seen = 1;
      prev_e = radar_echo;
    end
  endtask

  int lat, wid, rises, bseen;
  logic pe;

  initial begin
    rst = 1'b0; load_target = 1'b0; target_distance = '0;
    target_present = 1'b0; trig = 1'b0;
    tick(); tick();
    check("rst_echo",  {31'd0, radar_echo}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_miss",  {31'd0, missed_trigger}, 32'd0);
    check("rst_count", {24'd0, echo_count}, 32'd0);
    check("rst_range", {18'd0, current_range}, 32'd0);
    rst = 1'b1;
    tick();

    target_present = 1'b1;
    load(14'd1500);
    check("load_1500", {18'd0, current_range}, 32'd1500);
    ping_measure(20, lat, wid, rises, bseen);
    check("lat_1500", lat, 32'd11);
    check("wid_1500", wid, 32'd3);
    check("cnt_1", {24'd0, echo_count}, 32'd1);
    check("busy_after", {31'd0, busy}, 32'd0);

    load(14'd0);
    ping_measure(8, lat, wid, rises, bseen);
    check("lat_0", lat, 32'd1);
    check("wid_0", wid, 32'd3);

    load(14'd15001);
    ping_measure(40, lat, wid, rises, bseen);
    check("far_rises", rises, 32'd0);
    check("far_busy", bseen, 32'd0);

    load(14'd15000);
    ping_measure(110, lat, wid, rises, bseen);
    check("lat_15000", lat, 32'd101);
    check("cnt_3", {24'd0, echo_count}, 32'd3);

    load(14'd3000);
    trig = 1'b1; tick(); trig = 1'b0;
    tick(); tick(); tick();
    trig = 1'b1; tick(); trig = 1'b0;
    check("miss_hi", {31'd0, missed_trigger}, 32'd1);
    check("miss_busy", {31'd0, busy}, 32'd1);
    tick();
    check("miss_lo", {31'd0, missed_trigger}, 32'd0);
    lat = -1; rises = 0; pe = 1'b0;
    for (int k = 6; k <= 40; k++) begin
      tick();
      if (radar_echo && lat < 0) lat = k;
      if (radar_echo && !pe) rises++;
      pe = radar_echo;
    end
    check("lat_3000", lat, 32'd21);
    check("rises_3000", rises, 32'd1);
    check("cnt_4", {24'd0, echo_count}, 32'd4);

    target_present = 1'b0;
    ping_measure(30, lat, wid, rises, bseen);
    check("absent_rises", rises, 32'd0);
    check("absent_busy", bseen, 32'd0);
    target_present = 1'b1;

    rises = 0; pe = 1'b0;
    trig = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (radar_echo && !pe) rises++;
      pe = radar_echo;
    end
    trig = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (radar_echo && !pe) rises++;
      pe = radar_echo;
    end
    check("held_rises", rises, 32'd1);
    check("cnt_5", {24'd0, echo_count}, 32'd5);

    trig = 1'b1; tick(); trig = 1'b0;
    repeat (5) tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_echo",  {31'd0, radar_echo}, 32'd0);
    check("arst_busy",  {31'd0, busy}, 32'd0);
    check("arst_miss",  {31'd0, missed_trigger}, 32'd0);
    check("arst_count", {24'd0, echo_count}, 32'd0);
    check("arst_range", {18'd0, current_range}, 32'd0);
    tick();
    rst = 1'b1;
    rises = 0; bseen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (radar_echo) rises++;
      if (busy) bseen = 1;
    end
    check("post_rst_echo", rises, 32'd0);
    check("post_rst_busy", bseen, 32'd0);

    load(14'd600);
    ping_measure(12, lat, wid, rises, bseen);
`ifdef TARGET_MOTION_EN
    check("mot_r1", {18'd0, current_range}, 32'd300);
`else
    check("mot_r1", {18'd0, current_range}, 32'd600);
`endif
    ping_measure(12, lat, wid, rises, bseen);
`ifdef TARGET_MOTION_EN
    check("mot_r2", {18'd0, current_range}, 32'd0);
`else
    check("mot_r2", {18'd0, current_range}, 32'd600);
`endif
    ping_measure(12, lat, wid, rises, bseen);
`ifdef TARGET_MOTION_EN
    check("mot_r3", {18'd0, current_range}, 32'd0);
    check("mot_lat", lat, 32'd1);
`else
    check("mot_r3", {18'd0, current_range}, 32'd600);
    check("mot_lat", lat, 32'd5);
`endif
    check("cnt_mot", {24'd0, echo_count}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
